tristate_arbiter: RTL
=====================

# tristate_arbiter

Ownership controller for a shared tri-state line (LED pad or single-wire bus) driven by two on-chip sources. It produces the per-driver output-enables that select between each source and `1'bz`. It guarantees the two enables are never high together. It inserts a programmable dead time (line released, both enables low) on every change or renewal of ownership, and limits each grant to a maximum hold time.

## Interface
- `DEAD`, default 2: dead-time cycles with both enables low between grants; legal range ≥1.
- `MAX_HOLD`, default 12000000 (1 s at 12 MHz): maximum consecutive cycles one owner keeps the line; legal range ≥2.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req0` input 1: driver 0 requests the line; level-sensitive, held while it wants ownership.
- `req1` input 1: driver 1 requests the line; same rules as `req0`.
- `oe0` output 1: enable for driver 0's tri-state gate; registered.
- `oe1` output 1: enable for driver 1's tri-state gate; registered.
- `owner` output 1: index of the current or most recent grantee; registered.
- `busy` output 1: high in GRANT0, GRANT1 and DEAD; registered.

## Operation
- FSM states: IDLE, GRANT0, GRANT1, DEAD.
- Enables by state:
  - IDLE: `oe0`=`oe1`=0, `busy`=0.
  - GRANTx: only `oex`=1.
  - DEAD: both 0, `busy`=1.
- Priority pointer `last`: records the most recent grantee. On a tie (both requests high), the other driver wins. Reset value 1, so `req0` wins the first tie.
- IDLE: `req0` only → GRANT0; `req1` only → GRANT1; both → tie rule; neither → stay.
- GRANTx:
  - Hold counter counts cycles in the state, starting at 0 on entry.
  - Leave to DEAD when `reqx`=0 or the counter reaches `MAX_HOLD-1`, whichever comes first.
  - `last`←x on exit.
  - A request from the other driver never pre-empts before timeout.
- DEAD:
  - Dead counter loads `DEAD-1` on entry, decrements each cycle.
  - At 0, the next-state decision uses the IDLE rules, evaluated that cycle. The result is a grant or IDLE.
  - A grantee that timed out and is still the sole requester is re-granted after the full dead time.
- Invariant: `oe0 & oe1` is never 1, including during reset and every transition.
- Counters: hold counter width `$clog2(MAX_HOLD)`; dead counter width `$clog2(DEAD)+1`. No counter wraps; both are reloaded on state entry.

## Timing
- Reset: the edge sampling `rst`=1 sets `oe0`=`oe1`=0, `busy`=0, `owner`=0, `last`=1, state IDLE. `rst` overrides all inputs.
- Reset mid-grant: the enable drops on that same edge. No dead time is applied after reset, because IDLE already leaves the line released.
- Grant latency from IDLE: request high before edge n gives `oe` high after edge n, i.e. one cycle.
- Release: `reqx` low sampled at edge n gives `oex` low after edge n. Both enables are low for exactly `DEAD` cycles. The earliest next `oe` rises after edge n+`DEAD`.
- Timeout: `oex` is high for exactly `MAX_HOLD` cycles, then `DEAD` cycles low.
- Request glitches during DEAD are ignored. Only the value at the final DEAD cycle matters.
- `owner` updates on the same edge the new `oe` rises, and holds through DEAD and IDLE.

## Structure
- Shared header `tristate_arb.vh`, in the same style as `divider.vh`, holds:
  - state encodings `ST_IDLE`, `ST_GRANT0`, `ST_GRANT1`, `ST_DEAD` (2-bit);
  - the timing constant `T_1s` reused for the `MAX_HOLD` default.
- One sub-module, `load_counter`: a parameterised-width down-counter with synchronous load and a zero flag. It is instantiated twice, for hold and dead time.
- Top-level demo wrapper: two registered constant sources gated through `assign pin = oe0 ? d0 : (oe1 ? d1 : 1'bz)`. The wrapper is outside this block.

## Test plan
- Reset/idle: `rst`=1 for 3 cycles with `req0`=`req1`=1 → `oe0`=`oe1`=0, `busy`=0 throughout; the first edge after release gives `oe0`=1, `owner`=0.
- Single release, `DEAD`=2: `req0` pulse 5 cycles then `req1`=1 → `oe0` high 5 cycles, 2 cycles both low, then `oe1`=1, `owner`=1.
- Tie alternation: `req0`=`req1`=1 constantly, `MAX_HOLD`=4, `DEAD`=2 → repeating pattern `oe0`×4, gap×2, `oe1`×4, gap×2.
- Timeout re-grant: `req1` held alone, `MAX_HOLD`=4, `DEAD`=3 → `oe1`×4, gap×3, `oe1`×4; `owner` stays 1.
- Reset mid-grant: `rst` asserted in the 2nd cycle of GRANT0 → `oe0`=0 on that edge; after release with `req1`=1, `oe1` rises the next cycle; `last`=1, so a later tie goes to 0.
- Random req0/req1 for 10k cycles with assertions: never `oe0&oe1`; every owner change preceded by ≥`DEAD` both-low cycles; no `oe` high run exceeds `MAX_HOLD`.

Source files
------------

// File: rtl/tristate_arbiter_pkg.sv
// Shared definitions for the tri-state line arbiter: state encoding,
// timing constants and the request-to-grant decision used from IDLE and DEAD.
package tristate_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_DEAD   = 2'd3
  } arb_state_e;

  // One second at the 12 MHz system clock.
  localparam int T_1S = 12_000_000;

  // On a tie the driver that did not hold the line most recently wins.
  function automatic arb_state_e pick_grant(input logic req0, input logic req1,
                                            input logic last);
    arb_state_e pick;
    if (req0 && req1) begin
      pick = last ? ST_GRANT0 : ST_GRANT1;
    end else if (req0) begin
      pick = ST_GRANT0;
    end else if (req1) begin
      pick = ST_GRANT1;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/tristate_arbiter_if.sv
// Request/enable bundle between the two line drivers and the arbiter.
interface tristate_arbiter_if;
  logic req0;
  logic req1;
  logic oe0;
  logic oe1;
  logic owner;
  logic busy;

  modport master (output req0, output req1,
                  input oe0, input oe1, input owner, input busy);
  modport slave  (input req0, input req1,
                  output oe0, output oe1, output owner, output busy);
endinterface

// File: rtl/tristate_arbiter_load_counter.sv
// Down-counter with synchronous load; saturates at zero and flags it.
module load_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Load takes priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1'b1);
    end
  end

  assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/tristate_arbiter.sv
// Ownership controller for a shared tri-state line: mutually exclusive enables,
// dead time between grants and a bounded hold time per grant.
module tristate_arbiter
  import tristate_arbiter_pkg::*;
#(
  parameter int DEAD     = 2,
  parameter int MAX_HOLD = T_1S
) (
  input logic              clk,
  input logic              rst,
  tristate_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam int DEAD_W = $clog2(DEAD) + 1;

  arb_state_e state_r;
  arb_state_e next_state_s;
  logic       last_r;
  logic       in_grant_s;
  logic       in_dead_s;
  logic       hold_zero_s;
  logic       dead_zero_s;
  logic       oe0_s, oe1_s, busy_s, owner_s;
  logic       oe0_r, oe1_r, busy_r, owner_r;

  assign in_grant_s = (state_r == ST_GRANT0) || (state_r == ST_GRANT1);
  assign in_dead_s  = (state_r == ST_DEAD);

  // Both counters sit loaded outside their state, so each entry starts fresh.
  load_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (!in_grant_s),
    .load_val (HOLD_W'(MAX_HOLD - 1)),
    .dec      (in_grant_s),
    .zero     (hold_zero_s)
  );

  load_counter #(.WIDTH(DEAD_W)) u_dead_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (!in_dead_s),
    .load_val (DEAD_W'(DEAD - 1)),
    .dec      (in_dead_s),
    .zero     (dead_zero_s)
  );

  // State register and tie-break pointer, updated as a grant is given up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_GRANT0) && (next_state_s == ST_DEAD)) begin
        last_r <= 1'b0;
      end else if ((state_r == ST_GRANT1) && (next_state_s == ST_DEAD)) begin
        last_r <= 1'b1;
      end
    end
  end

  // Next-state decision; requests are only looked at in IDLE and the last DEAD cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        next_state_s = pick_grant(bus.req0, bus.req1, last_r);
      end
      ST_GRANT0: begin
        if (!bus.req0 || hold_zero_s) begin
          next_state_s = ST_DEAD;
        end else begin
          next_state_s = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (!bus.req1 || hold_zero_s) begin
          next_state_s = ST_DEAD;
        end else begin
          next_state_s = ST_GRANT1;
        end
      end
      ST_DEAD: begin
        if (dead_zero_s) begin
          next_state_s = pick_grant(bus.req0, bus.req1, last_r);
        end else begin
          next_state_s = ST_DEAD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs track state_r.
  always_comb begin
    oe0_s   = (next_state_s == ST_GRANT0);
    oe1_s   = (next_state_s == ST_GRANT1);
    busy_s  = (next_state_s != ST_IDLE);
    owner_s = owner_r;
    if (next_state_s == ST_GRANT0) begin
      owner_s = 1'b0;
    end else if (next_state_s == ST_GRANT1) begin
      owner_s = 1'b1;
    end else begin
      owner_s = owner_r;
    end
  end

  // Output registers; reset drops any enable on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe0_r   <= 1'b0;
      oe1_r   <= 1'b0;
      busy_r  <= 1'b0;
      owner_r <= 1'b0;
    end else begin
      oe0_r   <= oe0_s;
      oe1_r   <= oe1_s;
      busy_r  <= busy_s;
      owner_r <= owner_s;
    end
  end

  assign bus.oe0   = oe0_r;
  assign bus.oe1   = oe1_r;
  assign bus.busy  = busy_r;
  assign bus.owner = owner_r;

endmodule
